// File: rtl/prog_sequencer_pkg.sv
// Shared types and defaults for the program sequencer: opcode and FSM state
// encodings plus the default program entry points.
package prog_sequencer_pkg;

    localparam logic [7:0] START_A_DEF = 8'h00;
    localparam logic [7:0] START_B_DEF = 8'h40;
    localparam logic [8:0] IR_NOP      = 9'h1E0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ALU1 = 4'h1,
        OP_ALU2 = 4'h2,
        OP_ALU3 = 4'h3,
        OP_ALU4 = 4'h4,
        OP_EQ0  = 4'h5,
        OP_ALU6 = 4'h6,
        OP_ALU7 = 4'h7,
        OP_ALU8 = 4'h8,
        OP_ALU9 = 4'h9,
        OP_ALUA = 4'hA,
        OP_JMP  = 4'hB,
        OP_ALUC = 4'hC,
        OP_LDST = 4'hD,
        OP_HALT = 4'hE,
        OP_NOP  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

endpackage

// File: rtl/prog_sequencer_sat.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: fetch/decode/execute/memory FSM steering an external ALU,
// instruction memory and data memory, with run-cycle counter and sticky overflow.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter logic [7:0]  START_A = START_A_DEF,
    parameter logic [7:0]  START_B = START_B_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             prog_sel_i,
    input  logic [8:0]       instr_i,
    input  logic [7:0]       alu_out_i,
    input  logic             branch_taken_i,
    input  logic             overflow_i,
    input  logic             mem_ack_i,
    output logic [7:0]       pc_o,
    output logic             imem_en_o,
    output logic [3:0]       alu_opcode_o,
    output logic [7:0]       start_addr_o,
    output logic             reg_we_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             ovf_flag_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] start_addr_q, start_addr_d;
    logic [8:0] ir_q, ir_d;
    logic       ovf_q, ovf_d;
    logic       cnt_clr;
    logic [7:0] pc_inc;
    opcode_e    op;
    logic       ir_unused;

    assign op        = opcode_e'(ir_q[8:5]);
    assign pc_inc    = pc_q + 8'd1;
    // Operand field is consumed by the ALU from its own copy, not here.
    assign ir_unused = ^ir_q[4:1];

    assign pc_o         = pc_q;
    assign start_addr_o = start_addr_q;
    assign ovf_flag_o   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= START_A;
            start_addr_q <= START_A;
            ir_q         <= IR_NOP;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            start_addr_q <= start_addr_d;
            ir_q         <= ir_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        start_addr_d = start_addr_q;
        ir_d         = ir_q;
        ovf_d        = ovf_q;
        cnt_clr      = 1'b0;
        imem_en_o    = 1'b0;
        alu_opcode_o = 4'hF;
        reg_we_o     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                done_o = (state_q == S_HALT);
                if (start_i) begin
                    start_addr_d = prog_sel_i ? START_B : START_A;
                    pc_d         = prog_sel_i ? START_B : START_A;
                    ovf_d        = 1'b0;
                    cnt_clr      = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                busy_o    = 1'b1;
                imem_en_o = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                busy_o  = 1'b1;
                ir_d    = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy_o       = 1'b1;
                alu_opcode_o = ir_q[8:5];
                state_d      = S_FETCH;
                case (op)
                    OP_EQ0, OP_JMP: pc_d = branch_taken_i ? alu_out_i : pc_inc;
                    OP_LDST: begin
                        mem_we_o = ir_q[0];
                        state_d  = S_MEM;
                    end
                    OP_HALT: state_d = S_HALT;
                    OP_NOP:  pc_d = pc_inc;
                    default: begin
                        reg_we_o = 1'b1;
                        pc_d     = pc_inc;
                        if ((op == OP_ADD) && overflow_i) begin
                            ovf_d = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM: begin
                busy_o       = 1'b1;
                alu_opcode_o = ir_q[8:5];
                mem_req_o    = 1'b1;
                mem_we_o     = ir_q[0];
                if (mem_ack_i) begin
                    reg_we_o = ~ir_q[0];
                    pc_d     = pc_inc;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cycle_cnt (
        .clk  (clk),
        .reset(reset),
        .en_i (busy_o),
        .clr_i(cnt_clr),
        .cnt_o(cycle_cnt_o)
    );

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: instruction-level reference model,
// per-cycle compare process, directed literal pins and randomized programs.
module tb_prog_sequencer;

    localparam logic [7:0] START_A = 8'h00;
    localparam logic [7:0] START_B = 8'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        prog_sel_i = 1'b0;
    logic [8:0]  instr_i = '0;
    logic [7:0]  alu_out_i = '0;
    logic        branch_taken_i = 1'b0;
    logic        overflow_i = 1'b0;
    logic        mem_ack_i = 1'b0;

    logic [7:0]  pc_o, start_addr_o, s_pc, s_start_addr;
    logic        imem_en_o, reg_we_o, mem_req_o, mem_we_o, ovf_flag_o, busy_o, done_o;
    logic        s_imem_en, s_reg_we, s_mem_req, s_mem_we, s_ovf, s_busy, s_done;
    logic [3:0]  alu_opcode_o, s_opc;
    logic [15:0] cycle_cnt_o;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    prog_sequencer #(.START_A(START_A), .START_B(START_B), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
        .instr_i(instr_i), .alu_out_i(alu_out_i), .branch_taken_i(branch_taken_i),
        .overflow_i(overflow_i), .mem_ack_i(mem_ack_i), .pc_o(pc_o), .imem_en_o(imem_en_o),
        .alu_opcode_o(alu_opcode_o), .start_addr_o(start_addr_o), .reg_we_o(reg_we_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .ovf_flag_o(ovf_flag_o),
        .busy_o(busy_o), .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
    );

    // Narrow counter instance to reach saturation within a short program.
    prog_sequencer #(.START_A(START_A), .START_B(START_B), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .start_i(start_i), .prog_sel_i(prog_sel_i),
        .instr_i(instr_i), .alu_out_i(alu_out_i), .branch_taken_i(branch_taken_i),
        .overflow_i(overflow_i), .mem_ack_i(mem_ack_i), .pc_o(s_pc), .imem_en_o(s_imem_en),
        .alu_opcode_o(s_opc), .start_addr_o(s_start_addr), .reg_we_o(s_reg_we),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .ovf_flag_o(s_ovf),
        .busy_o(s_busy), .done_o(s_done), .cycle_cnt_o(s_cnt)
    );

    // Reference model state (architectural view).
    logic [7:0] m_pc = START_A;
    logic [7:0] m_base = START_A;
    bit         m_ovf = 1'b0;
    bit         m_halted = 1'b0;
    int         m_cnt = 0;
    bit         e_busy, e_done, e_imem, e_we, e_req, e_mwe;
    logic [3:0] e_opc = 4'hF;

    int n_checks = 0;
    int n_errors = 0;
    int we_total = 0;
    int req_total = 0;

    int    pin_kind [64];
    int    pin_exp  [64];
    string pin_name [64];
    int    pin_wr = 0;
    int    pin_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic int pin_actual(input int kind);
        case (kind)
            0:       return int'(pc_o);
            1:       return int'(cycle_cnt_o);
            2:       return int'(done_o);
            3:       return int'(ovf_flag_o);
            4:       return we_total;
            5:       return req_total;
            6:       return int'(busy_o);
            default: return int'(mem_req_o);
        endcase
    endfunction

    always @(negedge clk) begin
        int c3, c16;
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c3  = (m_cnt > 7) ? 7 : m_cnt;
        chk("pc", 32'(pc_o), 32'(m_pc));
        chk("start_addr", 32'(start_addr_o), 32'(m_base));
        chk("ovf", 32'(ovf_flag_o), 32'(m_ovf));
        chk("cycle_cnt", 32'(cycle_cnt_o), 32'(c16));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("done", 32'(done_o), 32'(e_done));
        chk("imem_en", 32'(imem_en_o), 32'(e_imem));
        chk("alu_opcode", 32'(alu_opcode_o), 32'(e_opc));
        chk("reg_we", 32'(reg_we_o), 32'(e_we));
        chk("mem_req", 32'(mem_req_o), 32'(e_req));
        chk("mem_we", 32'(mem_we_o), 32'(e_mwe));
        chk("small_cnt", 32'(s_cnt), 32'(c3));
        chk("small_ctl", {16'(s_pc), 8'(s_start_addr), s_imem_en, s_reg_we, s_mem_req,
                          s_mem_we, s_ovf, s_busy, s_done, 1'b0},
                         {16'(m_pc), 8'(m_base), e_imem, e_we, e_req, e_mwe, m_ovf,
                          e_busy, e_done, 1'b0});
        chk("small_opc", 32'(s_opc), 32'(e_opc));
        while (pin_rd != pin_wr) begin
            chk(pin_name[pin_rd % 64], 32'(pin_actual(pin_kind[pin_rd % 64])),
                32'(pin_exp[pin_rd % 64]));
            pin_rd++;
        end
        if (reg_we_o) we_total++;
        if (mem_req_o) req_total++;
    end

    task automatic pin(input int kind, input int expv, input string name);
        pin_kind[pin_wr % 64] = kind;
        pin_exp[pin_wr % 64]  = expv;
        pin_name[pin_wr % 64] = name;
        pin_wr++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_step();
        step();
        m_cnt++;
    endtask

    task automatic set_exp(input bit busy, input bit done, input bit imem, input logic [3:0] opc,
                           input bit we, input bit req, input bit mwe);
        e_busy = busy; e_done = done; e_imem = imem; e_opc = opc;
        e_we = we; e_req = req; e_mwe = mwe;
    endtask

    function automatic bit noise_bit(input int noise);
        if (noise == 2) return 1'b1;
        if (noise == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pc = START_A; m_base = START_A; m_ovf = 0; m_cnt = 0; m_halted = 0;
    endtask

    task automatic idle_cycle(input bit do_start, input bit sel);
        start_i = do_start;
        prog_sel_i = sel;
        mem_ack_i = 1'($urandom_range(0, 1));
        set_exp(0, m_halted, 0, 4'hF, 0, 0, 0);
        step();
        start_i = 0;
        mem_ack_i = 0;
        if (do_start) begin
            m_base = sel ? START_B : START_A;
            m_pc = m_base; m_ovf = 0; m_cnt = 0; m_halted = 0;
        end
    endtask

    task automatic exec_front(input logic [3:0] op, input logic [4:0] lo, input logic [7:0] alu,
                              input bit taken, input bit ovf, input int noise);
        bit is_alu;
        is_alu = (op <= 4'hC) && (op != 4'h5) && (op != 4'hB);
        instr_i = 9'($urandom); start_i = noise_bit(noise); prog_sel_i = 1'($urandom);
        mem_ack_i = noise_bit(noise);
        set_exp(1, 0, 1, 4'hF, 0, 0, 0);
        busy_step();
        instr_i = {op, lo}; start_i = noise_bit(noise); mem_ack_i = noise_bit(noise);
        set_exp(1, 0, 0, 4'hF, 0, 0, 0);
        busy_step();
        instr_i = 9'($urandom); start_i = noise_bit(noise); mem_ack_i = noise_bit(noise);
        alu_out_i = alu; branch_taken_i = taken; overflow_i = ovf;
        set_exp(1, 0, 0, op, is_alu, 0, (op == 4'hD) ? lo[0] : 1'b0);
        busy_step();
        start_i = 0; mem_ack_i = 0;
    endtask

    task automatic exec_instr(input logic [3:0] op, input logic [4:0] lo, input logic [7:0] alu,
                              input bit taken, input bit ovf, input int dly, input int noise);
        exec_front(op, lo, alu, taken, ovf, noise);
        if (op == 4'h5 || op == 4'hB) begin
            m_pc = taken ? alu : m_pc + 8'd1;
        end else if (op == 4'hE) begin
            m_halted = 1;
        end else if (op == 4'hD) begin
            for (int i = 0; i <= dly; i++) begin
                mem_ack_i = (i == dly);
                start_i = noise_bit(noise);
                set_exp(1, 0, 0, 4'hD, (i == dly) && !lo[0], 1, lo[0]);
                busy_step();
            end
            mem_ack_i = 0; start_i = 0;
            m_pc = m_pc + 8'd1;
        end else if (op == 4'hF) begin
            m_pc = m_pc + 8'd1;
        end else begin
            m_pc = m_pc + 8'd1;
            if (op == 4'h0 && ovf) m_ovf = 1;
        end
    endtask

    initial begin
        int we_base, req_base, n_ins;
        logic [3:0] op;

        model_reset();
        set_exp(0, 0, 0, 4'hF, 0, 0, 0);
        step();
        pin(0, 8'h00, "reset_pc");
        pin(6, 0, "reset_busy");
        step();
        reset = 0;

        // Program B: add then halt.
        we_base = we_total;
        idle_cycle(0, 0);
        idle_cycle(1, 1);
        pin(0, 8'h40, "progB_entry_pc");
        exec_instr(4'h0, 5'h03, 8'h00, 0, 0, 0, 0);
        exec_instr(4'hE, 5'h00, 8'h00, 0, 0, 0, 0);
        pin(2, 1, "progB_done");
        pin(0, 8'h41, "progB_pc");
        pin(1, 6, "progB_cycles");
        pin(4, we_base + 1, "progB_we_pulses");

        // Branches.
        idle_cycle(1, 0);
        exec_instr(4'hB, 5'h01, 8'h4A, 1, 0, 0, 0);
        pin(0, 8'h4A, "jmp_taken_pc");
        exec_instr(4'h5, 5'h02, 8'h77, 0, 0, 0, 0);
        pin(0, 8'h4B, "eq0_not_taken_pc");

        // Load with 3-cycle ack delay, then store.
        we_base = we_total; req_base = req_total;
        exec_instr(4'hD, 5'h10, 8'h00, 0, 0, 3, 0);
        pin(5, req_base + 4, "load_req_cycles");
        pin(4, we_base + 1, "load_we_pulses");
        pin(0, 8'h4C, "load_pc");
        exec_instr(4'hD, 5'h11, 8'h00, 0, 0, 2, 0);
        pin(4, we_base + 1, "store_no_we");
        pin(5, req_base + 7, "store_req_cycles");

        // PC wrap and sticky overflow.
        exec_instr(4'hB, 5'h00, 8'hFF, 1, 0, 0, 0);
        exec_instr(4'hF, 5'h00, 8'h00, 0, 0, 0, 0);
        pin(0, 8'h00, "pc_wrap");
        exec_instr(4'h0, 5'h00, 8'h00, 0, 1, 0, 0);
        pin(3, 1, "ovf_set");
        exec_instr(4'h0, 5'h00, 8'h00, 0, 0, 0, 0);
        exec_instr(4'h3, 5'h00, 8'h00, 0, 1, 0, 0);
        exec_instr(4'hE, 5'h00, 8'h00, 0, 0, 0, 0);
        pin(3, 1, "ovf_at_halt");
        idle_cycle(0, 0);
        idle_cycle(1, 1);
        pin(3, 0, "ovf_cleared_by_start");

        // start_i held high throughout a jump must be ignored.
        exec_instr(4'hB, 5'h00, 8'h12, 1, 0, 0, 2);
        pin(0, 8'h12, "start_ignored_pc");
        pin(1, 3, "start_ignored_cnt");

        // Reset asserted during MEM.
        we_base = we_total;
        exec_front(4'hD, 5'h00, 8'h00, 0, 0, 0);
        set_exp(1, 0, 0, 4'hD, 0, 1, 0);
        busy_step();
        set_exp(1, 0, 0, 4'hD, 0, 1, 0);
        #1;
        reset = 1;
        model_reset();
        set_exp(0, 0, 0, 4'hF, 0, 0, 0);
        pin(7, 0, "reset_mem_req");
        pin(0, 8'h00, "reset_mem_pc");
        pin(6, 0, "reset_mem_busy");
        step();
        step();
        reset = 0;
        idle_cycle(0, 0);
        pin(4, we_base, "reset_mem_no_writeback");

        // Randomized programs.
        for (int p = 0; p < 40; p++) begin
            idle_cycle(1, 1'($urandom));
            n_ins = $urandom_range(2, 20);
            for (int k = 0; k < n_ins; k++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hE) op = 4'hF;
                exec_instr(op, 5'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                           $urandom_range(0, 4), 1);
            end
            exec_instr(4'hE, 5'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, 1);
            for (int h = 0; h < $urandom_range(1, 3); h++) idle_cycle(0, 0);
        end

        set_exp(0, m_halted, 0, 4'hF, 0, 0, 0);
        step();
        #6;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter START_A, default 8'h00, program-A entry PC and ALU label-table base.
REQ-002 Parameter START_B, default 8'h40, program-B entry PC and ALU label-table base.
REQ-003 Parameter CNT_W, default 16, cycle-counter width.
REQ-004 The module SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-005 Ports SHALL be exactly:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start_i  in  1  one-cycle start pulse
- prog_sel_i  in  1  0=START_A, 1=START_B
- instr_i  in  9  imem data, valid the cycle after imem_en_o
- alu_out_i  in  8  ALU result / branch target
- branch_taken_i  in  1  ALU taken flag
- overflow_i  in  1  ALU add overflow
- mem_ack_i  in  1  data-memory completion
- pc_o  out  8  current PC
- imem_en_o  out  1  instruction-fetch strobe
- alu_opcode_o  out  4  opcode to ALU
- start_addr_o  out  8  latched program base to ALU
- reg_we_o  out  1  register-file write enable
- mem_req_o  out  1  data-memory request
- mem_we_o  out  1  1=store
- ovf_flag_o  out  1  sticky overflow
- busy_o  out  1  program running
- done_o  out  1  program halted
- cycle_cnt_o  out  CNT_W  run-cycle count

Function
REQ-006 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, HALT.
REQ-007 IDLE: on start_i, pc, start_addr <= START_A/START_B per prog_sel_i; cycle_cnt, ovf_flag <= 0; next state FETCH.
REQ-008 FETCH: imem_en_o=1 for one cycle; next state DECODE.
REQ-009 DECODE: IR <= instr_i; next state EXEC.
REQ-010 alu_opcode_o SHALL equal IR[8:5] in EXEC and MEM, and 4'hF otherwise.
REQ-011 EXEC, opcodes 0x0-0xC except 0x5/0xB: reg_we_o=1 for one cycle; pc <= pc+1; next state FETCH.
REQ-012 EXEC, 0x5 (eq0) and 0xB (jmp): reg_we_o=0; pc <= alu_out_i if branch_taken_i, else pc+1; next state FETCH.
REQ-013 EXEC, 0x0 with overflow_i=1: ovf_flag <= 1, held until the next accepted start_i.
REQ-014 EXEC, 0xD: next state MEM; mem_we_o = IR[0], held constant through MEM.
REQ-015 MEM: mem_req_o held high until mem_ack_i, with no timeout. On the ack cycle: reg_we_o = ~IR[0]; pc <= pc+1; next state FETCH; mem_req_o low the following cycle.
REQ-016 EXEC, 0xF (nop): pc <= pc+1; next state FETCH.
REQ-017 EXEC, 0xE (halt): pc unchanged; next state HALT.
REQ-018 HALT: done_o=1; start_i restarts exactly as from IDLE.
REQ-019 start_i SHALL be ignored in FETCH, DECODE, EXEC and MEM.
REQ-020 pc arithmetic SHALL be 8-bit modulo: 8'hFF+1 = 8'h00.
REQ-021 busy_o = 1 in FETCH/DECODE/EXEC/MEM.
REQ-022 cycle_cnt SHALL increment every busy cycle and saturate at all-ones.
REQ-023 mem_ack_i outside MEM SHALL be ignored.

Reset
REQ-024 Reset SHALL force, asynchronously: state=IDLE; pc=START_A; start_addr=START_A; IR=9'h1E0 (nop); cycle_cnt=0; ovf_flag=0; all strobes, busy_o and done_o low.
REQ-025 Reset asserted mid-MEM SHALL drop mem_req_o immediately, with no write-back.

Structure
REQ-026 A shared package SHALL hold: the opcode enum (0x0-0xC ALU, 0x5 eq0, 0xB jmp, 0xD ldst, 0xE halt, 0xF nop), the state enum, and START_A/START_B defaults.
REQ-027 A single sub-module, sat_counter (CNT_W, enable, clear), SHALL implement cycle_cnt.

Verification
REQ-028 prog_sel_i=1, start_i, imem {add, halt}: pc 40->41, reg_we_o one pulse, done_o after 7 cycles, cycle_cnt_o=6.
REQ-029 jmp with alu_out_i=8'h4A, taken=1 -> pc_o=4A next FETCH; eq0 with taken=0 -> pc+1.
REQ-030 load with mem_ack_i delayed 3 cycles -> mem_req_o high 4 cycles, reg_we_o only on ack cycle; store -> reg_we_o never high.
REQ-031 pc=FF executing nop -> pc_o=00; add with overflow_i=1 -> ovf_flag_o stays 1 through halt.
REQ-032 reset pulsed during MEM -> mem_req_o low same cycle, pc_o=00, busy_o=0; start_i pulsed during EXEC -> no effect.
